alu_shift_rs: RTL

Reservation station for the integer ALU and shifter functional groups. It sits directly downstream of the instruction decoder and rename. It holds up to DEPTH decoded ops (func group, alu/shift op type, destination and source tags) until both source operands are ready, waking them up from common-data-bus (CDB) broadcasts. It then issues one ready op per cycle to the ALU/SHIFT execute stage over a valid/ready handshake.

---
 rtl/alu_shift_rs_if.sv | 87 ++++++++
 rtl/alu_shift_rs.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/alu_shift_rs_if.sv
// Shared op encodings and the dispatch/CDB/issue bundle of the
// ALU/shift reservation station.
package alu_shift_pkg;
    typedef enum logic [0:0] {
        FG_ALU   = 1'b0,
        FG_SHIFT = 1'b1
    } functional_group_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_ADDI = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7
    } alu_op_t;

    typedef enum logic [2:0] {
        SH_SLL  = 3'd0,
        SH_SRL  = 3'd1,
        SH_SRA  = 3'd2,
        SH_SLLI = 3'd3,
        SH_SRLI = 3'd4,
        SH_SRAI = 3'd5,
        SH_SRAR = 3'd6
    } shift_op_t;
endpackage

interface alu_shift_rs_if #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
);
    import alu_shift_pkg::*;

    logic              flush_i;
    logic              disp_valid_i;
    logic              disp_ready_o;
    functional_group_t disp_func_group_i;
    alu_op_t           disp_alu_op_i;
    shift_op_t         disp_shift_op_i;
    logic [TAG_W-1:0]  disp_rd_tag_i;
    logic              disp_rs1_rdy_i;
    logic              disp_rs2_rdy_i;
    logic [TAG_W-1:0]  disp_rs1_tag_i;
    logic [TAG_W-1:0]  disp_rs2_tag_i;
    logic [DATA_W-1:0] disp_rs1_val_i;
    logic [DATA_W-1:0] disp_rs2_val_i;
    logic              cdb_valid_i;
    logic [TAG_W-1:0]  cdb_tag_i;
    logic [DATA_W-1:0] cdb_val_i;
    logic              issue_valid_o;
    logic              issue_ready_i;
    functional_group_t issue_func_group_o;
    alu_op_t           issue_alu_op_o;
    shift_op_t         issue_shift_op_o;
    logic [TAG_W-1:0]  issue_rd_tag_o;
    logic [DATA_W-1:0] issue_rs1_val_o;
    logic [DATA_W-1:0] issue_rs2_val_o;
    logic [$clog2(DEPTH+1)-1:0] count_o;

    modport slave (
        input  flush_i, disp_valid_i, disp_func_group_i,
        input  disp_alu_op_i, disp_shift_op_i, disp_rd_tag_i,
        input  disp_rs1_rdy_i, disp_rs2_rdy_i,
        input  disp_rs1_tag_i, disp_rs2_tag_i,
        input  disp_rs1_val_i, disp_rs2_val_i,
        input  cdb_valid_i, cdb_tag_i, cdb_val_i, issue_ready_i,
        output disp_ready_o, issue_valid_o, issue_func_group_o,
        output issue_alu_op_o, issue_shift_op_o, issue_rd_tag_o,
        output issue_rs1_val_o, issue_rs2_val_o, count_o
    );

    modport master (
        output flush_i, disp_valid_i, disp_func_group_i,
        output disp_alu_op_i, disp_shift_op_i, disp_rd_tag_i,
        output disp_rs1_rdy_i, disp_rs2_rdy_i,
        output disp_rs1_tag_i, disp_rs2_tag_i,
        output disp_rs1_val_i, disp_rs2_val_i,
        output cdb_valid_i, cdb_tag_i, cdb_val_i, issue_ready_i,
        input  disp_ready_o, issue_valid_o, issue_func_group_o,
        input  issue_alu_op_o, issue_shift_op_o, issue_rd_tag_o,
        input  issue_rs1_val_o, issue_rs2_val_o, count_o
    );
endinterface

// File: rtl/alu_shift_rs.sv
// ALU/shift reservation station: holds decoded ops until both
// operands are woken by the CDB, then issues one per cycle.
module alu_shift_rs
    import alu_shift_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    alu_shift_rs_if.slave rs
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              valid;
        functional_group_t fg;
        alu_op_t           aop;
        shift_op_t         sop;
        logic [TAG_W-1:0]  rd;
        logic              r1;
        logic [TAG_W-1:0]  t1;
        logic [DATA_W-1:0] v1;
        logic              r2;
        logic [TAG_W-1:0]  t2;
        logic [DATA_W-1:0] v2;
    } entry_t;

    entry_t             ent_q [DEPTH];
    entry_t             ent_d [DEPTH];
    logic               lock_q, lock_d;
    logic [IDX_W-1:0]   lidx_q, lidx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               any_free, any_rdy, issue_v;
    logic [IDX_W-1:0]   free_idx, rdy_idx, sel_idx;
    logic               disp_fire, issue_fire;
    logic               byp1, byp2;

    // Descending scan leaves the lowest matching index.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        any_rdy  = 1'b0;
        rdy_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_q[i].valid) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (ent_q[i].valid && ent_q[i].r1 && ent_q[i].r2) begin
                any_rdy = 1'b1;
                rdy_idx = IDX_W'(i);
            end
        end
        sel_idx = lock_q ? lidx_q : rdy_idx;
        issue_v = lock_q | any_rdy;
    end

    assign rs.disp_ready_o       = any_free;
    assign rs.count_o            = cnt_q;
    assign rs.issue_valid_o      = issue_v;
    assign rs.issue_func_group_o = issue_v ? ent_q[sel_idx].fg : FG_ALU;
    assign rs.issue_alu_op_o     = issue_v ? ent_q[sel_idx].aop : ALU_ADD;
    assign rs.issue_shift_op_o   = issue_v ? ent_q[sel_idx].sop : SH_SLL;
    assign rs.issue_rd_tag_o     = issue_v ? ent_q[sel_idx].rd : '0;
    assign rs.issue_rs1_val_o    = issue_v ? ent_q[sel_idx].v1 : '0;
    assign rs.issue_rs2_val_o    = issue_v ? ent_q[sel_idx].v2 : '0;

    always_comb begin
        ent_d      = ent_q;
        lock_d     = lock_q;
        lidx_d     = lidx_q;
        cnt_d      = cnt_q;
        disp_fire  = rs.disp_valid_i & any_free;
        issue_fire = issue_v & rs.issue_ready_i;
        byp1 = !rs.disp_rs1_rdy_i && rs.cdb_valid_i
             && rs.disp_rs1_tag_i == rs.cdb_tag_i;
        byp2 = !rs.disp_rs2_rdy_i && rs.cdb_valid_i
             && rs.disp_rs2_tag_i == rs.cdb_tag_i;

        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid && !ent_q[i].r1 && rs.cdb_valid_i
                && ent_q[i].t1 == rs.cdb_tag_i) begin
                ent_d[i].r1 = 1'b1;
                ent_d[i].v1 = rs.cdb_val_i;
            end
            if (ent_q[i].valid && !ent_q[i].r2 && rs.cdb_valid_i
                && ent_q[i].t2 == rs.cdb_tag_i) begin
                ent_d[i].r2 = 1'b1;
                ent_d[i].v2 = rs.cdb_val_i;
            end
        end

        if (issue_fire)
            ent_d[sel_idx].valid = 1'b0;

        // free_idx is never the issuing entry, so no write conflict.
        if (disp_fire) begin
            ent_d[free_idx].valid = 1'b1;
            ent_d[free_idx].fg    = rs.disp_func_group_i;
            ent_d[free_idx].aop   = rs.disp_alu_op_i;
            ent_d[free_idx].sop   = rs.disp_shift_op_i;
            ent_d[free_idx].rd    = rs.disp_rd_tag_i;
            ent_d[free_idx].r1    = rs.disp_rs1_rdy_i | byp1;
            ent_d[free_idx].t1    = rs.disp_rs1_tag_i;
            ent_d[free_idx].v1    = byp1 ? rs.cdb_val_i : rs.disp_rs1_val_i;
            ent_d[free_idx].r2    = rs.disp_rs2_rdy_i | byp2;
            ent_d[free_idx].t2    = rs.disp_rs2_tag_i;
            ent_d[free_idx].v2    = byp2 ? rs.cdb_val_i : rs.disp_rs2_val_i;
        end

        if (issue_fire) begin
            lock_d = 1'b0;
        end else if (issue_v) begin
            lock_d = 1'b1;
            lidx_d = sel_idx;
        end

        if (disp_fire && !issue_fire)
            cnt_d = cnt_q + CNT_W'(1);
        else if (issue_fire && !disp_fire)
            cnt_d = cnt_q - CNT_W'(1);

        if (rs.flush_i) begin
            for (int i = 0; i < DEPTH; i++)
                ent_d[i].valid = 1'b0;
            lock_d = 1'b0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++)
                ent_q[i] <= '0;
            lock_q <= 1'b0;
            lidx_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                ent_q[i] <= ent_d[i];
            lock_q <= lock_d;
            lidx_q <= lidx_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule
